// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI frame sequencer.
package spi_pkg;

  localparam int SPI_MAX_BITS = 32;
  localparam int SPI_WORD_W   = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } frame_state_e;

endpackage

// File: rtl/mod_counter.sv
// Modulo counter: counts 0..limit and wraps, with synchronous clear.
module mod_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] limit,
  output logic [W-1:0] count,
  output logic         wrap
);

  // limit is the terminal value, so the count never reaches limit+1.
  assign wrap = inc && (count == limit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= wrap ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/spi_frame_counter.sv
// Bit/word sequencer for the SPI datapath: counts ticked bits per word and
// words per frame, emitting word and frame boundary pulses.
module spi_frame_counter
  import spi_pkg::*;
#(
  parameter int MAX_BITS = SPI_MAX_BITS,
  parameter int WORD_W   = SPI_WORD_W,
  parameter int BIT_W    = $clog2(MAX_BITS + 1),
  parameter int IDX_W    = $clog2(MAX_BITS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              bit_tick,
  input  logic [BIT_W-1:0]  cfg_bits,
  input  logic [WORD_W-1:0] cfg_words,
  output logic              busy,
  output logic [IDX_W-1:0]  bit_idx,
  output logic [WORD_W-1:0] word_idx,
  output logic              last_bit,
  output logic              last_word,
  output logic              word_done,
  output logic              frame_done,
  output logic              cfg_err,
  output frame_state_e      state
);

  // Handshake: bit_tick is a qualified single-cycle strobe with no ready;
  // every tick seen in RUN is consumed on that edge, so none can be lost.

  frame_state_e next_state;

  logic [BIT_W-1:0]  bits_q;
  logic [WORD_W-1:0] words_q;
  logic              cfg_ok;
  logic              start_ok;
  logic              cnt_clr;
  logic              bit_inc;
  logic              bit_wrap;
  logic              word_wrap;
  logic [IDX_W-1:0]  bit_last;
  logic [WORD_W-1:0] word_last;

  assign cfg_ok   = (cfg_bits != '0) && (cfg_bits <= BIT_W'(MAX_BITS)) &&
                    (cfg_words != '0);
  assign start_ok = (state == IDLE) && start && !abort && cfg_ok;
  assign cnt_clr  = abort || start_ok;
  assign bit_inc  = (state == RUN) && bit_tick;

  // bits_q is never 0 while running, so the cast drops no live bit.
  assign bit_last  = IDX_W'(bits_q - 1'b1);
  assign word_last = words_q - 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    if (abort) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:    if (start_ok) next_state = RUN;
        RUN:     if (bit_wrap && word_wrap) next_state = DONE;
        DONE:    next_state = IDLE;
        default: next_state = IDLE;
      endcase
    end
  end

  always_comb begin
    busy      = (state == RUN);
    last_bit  = busy && (bit_idx == bit_last);
    last_word = busy && (word_idx == word_last);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bits_q  <= '0;
      words_q <= '0;
    end else if (start_ok) begin
      bits_q  <= cfg_bits;
      words_q <= cfg_words;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_done  <= 1'b0;
      frame_done <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      word_done  <= bit_wrap && !abort;
      frame_done <= bit_wrap && word_wrap && !abort;
      cfg_err    <= (state == IDLE) && start && !abort && !cfg_ok;
    end
  end

  mod_counter #(.W(IDX_W)) u_bit_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .inc   (bit_inc),
    .limit (bit_last),
    .count (bit_idx),
    .wrap  (bit_wrap)
  );

  mod_counter #(.W(WORD_W)) u_word_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .inc   (bit_wrap),
    .limit (word_last),
    .count (word_idx),
    .wrap  (word_wrap)
  );

endmodule

// File: tb/tb_spi_frame_counter.sv
// Bench for spi_frame_counter: directed scenarios plus random traffic,
// checked against a tick-count model of the frame.
module tb_spi_frame_counter;
  import spi_pkg::*;

  localparam int BIT_W  = 6;
  localparam int IDX_W  = 5;
  localparam int WORD_W = 8;
  localparam int VW     = 1 + IDX_W + WORD_W + 5 + 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic              bit_tick = 1'b0;
  logic [BIT_W-1:0]  cfg_bits = '0;
  logic [WORD_W-1:0] cfg_words = '0;
  logic              busy, last_bit, last_word, word_done, frame_done, cfg_err;
  logic [IDX_W-1:0]  bit_idx;
  logic [WORD_W-1:0] word_idx;
  frame_state_e      state;

  spi_frame_counter dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .bit_tick(bit_tick),
    .cfg_bits(cfg_bits), .cfg_words(cfg_words), .busy(busy), .bit_idx(bit_idx),
    .word_idx(word_idx), .last_bit(last_bit), .last_word(last_word),
    .word_done(word_done), .frame_done(frame_done), .cfg_err(cfg_err),
    .state(state)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Model: a frame is just a running count of ticks against bits*words.
  logic m_run, m_done, m_wd, m_fd, m_err;
  int   m_ticks, m_bits, m_words;

  task automatic model_reset();
    m_run = 0; m_done = 0; m_wd = 0; m_fd = 0; m_err = 0;
    m_ticks = 0; m_bits = 0; m_words = 0;
  endtask

  task automatic model_step(input logic s, input logic a, input logic t);
    int nb, nw;
    nb = int'(cfg_bits);
    nw = int'(cfg_words);
    m_wd = 0; m_fd = 0; m_err = 0;
    if (a) begin
      m_run = 0; m_done = 0;
    end else if (m_done) begin
      m_done = 0;
    end else if (m_run) begin
      if (t) begin
        m_ticks++;
        if (m_ticks % m_bits == 0) m_wd = 1;
        if (m_ticks == m_bits * m_words) begin
          m_fd = 1; m_run = 0; m_done = 1;
        end
      end
    end else if (s) begin
      if (nb >= 1 && nb <= 32 && nw != 0) begin
        m_bits = nb; m_words = nw; m_ticks = 0; m_run = 1;
      end else begin
        m_err = 1;
      end
    end
  endtask

  function automatic logic [VW-1:0] exp_vec();
    logic [IDX_W-1:0]  bi;
    logic [WORD_W-1:0] wi;
    logic              lb, lw;
    logic [1:0]        st;
    bi = '0; wi = '0; lb = 0; lw = 0;
    if (m_run) begin
      bi = IDX_W'(m_ticks % m_bits);
      wi = WORD_W'(m_ticks / m_bits);
      lb = (m_ticks % m_bits) == m_bits - 1;
      lw = (m_ticks / m_bits) == m_words - 1;
    end
    st = m_run ? 2'd1 : (m_done ? 2'd2 : 2'd0);
    return {m_run, bi, wi, lb, lw, m_wd, m_fd, m_err, st};
  endfunction

  function automatic logic [VW-1:0] obs_vec();
    return {busy, bit_idx, word_idx, last_bit, last_word, word_done,
            frame_done, cfg_err, 2'(state)};
  endfunction

  // Inputs change 1 time unit after the rising edge; outputs are read there too.
  task automatic step(input logic s, input logic a, input logic t);
    start = s; abort = a; bit_tick = t;
    @(posedge clk);
    #1;
    model_step(s, a, t);
    start = 0; abort = 0; bit_tick = 0;
  endtask

  task automatic test_reset();
    model_reset();
    #1;
    total++;
    if (obs_vec() !== exp_vec()) begin
      bad++; $display("FAIL reset_init got=%h want=%h", obs_vec(), exp_vec());
    end
    @(posedge clk); #1;
    rst = 0;
    step(0, 0, 1);
    total++;
    if (obs_vec() !== exp_vec()) begin
      bad++; $display("FAIL reset_idle_tick got=%h want=%h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_reset_mid();
    cfg_bits = 8; cfg_words = 3;
    step(1, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 1);
    total++;
    if (obs_vec() !== exp_vec()) begin
      bad++; $display("FAIL reset_mid_pre got=%h want=%h", obs_vec(), exp_vec());
    end
    rst = 1;
    #1;
    model_reset();
    total++;
    if (obs_vec() !== exp_vec()) begin
      bad++; $display("FAIL reset_mid_async got=%h want=%h", obs_vec(), exp_vec());
    end
    #1 rst = 0;
    step(1, 0, 0);
    for (int i = 0; i < 26; i++) begin
      step(0, 0, 1);
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL reset_mid_frame i=%0d got=%h want=%h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_basic();
    int nwd, nfd;
    nwd = 0; nfd = 0;
    cfg_bits = 8; cfg_words = 3;
    step(1, 0, 0);
    total++;
    if (obs_vec() !== exp_vec()) begin
      bad++; $display("FAIL basic_start got=%h want=%h", obs_vec(), exp_vec());
    end
    for (int i = 0; i < 24; i++) begin
      step(0, 0, 1);
      nwd += int'(word_done); nfd += int'(frame_done);
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL basic_tick i=%0d got=%h want=%h", i, obs_vec(), exp_vec());
      end
      step(0, 0, 0);
      nwd += int'(word_done); nfd += int'(frame_done);
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL basic_gap i=%0d got=%h want=%h", i, obs_vec(), exp_vec());
      end
    end
    total++;
    if (nwd !== 3 || nfd !== 1) begin
      bad++; $display("FAIL basic_pulses got=%0d/%0d want=3/1", nwd, nfd);
    end
  endtask

  task automatic test_boundary();
    int nwd, nfd;
    cfg_bits = 1; cfg_words = 1;
    step(1, 0, 0);
    step(0, 0, 1);
    total++;
    if (obs_vec() !== exp_vec() || !word_done || !frame_done) begin
      bad++; $display("FAIL one_by_one got=%h want=%h", obs_vec(), exp_vec());
    end
    step(0, 0, 0);
    nwd = 0; nfd = 0;
    cfg_bits = 32; cfg_words = 255;
    step(1, 0, 0);
    for (int i = 0; i < 8160; i++) begin
      step(0, 0, 1);
      nwd += int'(word_done); nfd += int'(frame_done);
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL max_frame i=%0d got=%h want=%h", i, obs_vec(), exp_vec());
      end
    end
    step(0, 0, 1);
    total++;
    if (nwd !== 255 || nfd !== 1 || obs_vec() !== exp_vec()) begin
      bad++; $display("FAIL max_pulses got=%0d/%0d want=255/1", nwd, nfd);
    end
  endtask

  task automatic test_invalid();
    logic [BIT_W-1:0]  bl[3];
    logic [WORD_W-1:0] wl[3];
    bl[0] = 0; bl[1] = 33; bl[2] = 8;
    wl[0] = 3; wl[1] = 3;  wl[2] = 0;
    for (int i = 0; i < 3; i++) begin
      cfg_bits = bl[i]; cfg_words = wl[i];
      step(1, 0, 0);
      total++;
      if (obs_vec() !== exp_vec() || cfg_err !== 1'b1) begin
        bad++; $display("FAIL invalid_err i=%0d got=%h want=%h", i, obs_vec(), exp_vec());
      end
      step(0, 0, 1);
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL invalid_after i=%0d got=%h want=%h", i, obs_vec(), exp_vec());
      end
    end
    cfg_bits = 0; cfg_words = 1;
    step(1, 1, 0);
    total++;
    if (obs_vec() !== exp_vec()) begin
      bad++; $display("FAIL abort_start_bad got=%h want=%h", obs_vec(), exp_vec());
    end
    cfg_bits = 4; cfg_words = 1;
    step(1, 1, 0);
    total++;
    if (obs_vec() !== exp_vec()) begin
      bad++; $display("FAIL abort_start_good got=%h want=%h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_abort_final();
    cfg_bits = 4; cfg_words = 2;
    step(1, 0, 0);
    for (int i = 0; i < 7; i++) step(0, 0, 1);
    total++;
    if (obs_vec() !== exp_vec()) begin
      bad++; $display("FAIL abort_pre got=%h want=%h", obs_vec(), exp_vec());
    end
    step(0, 1, 1);
    total++;
    if (obs_vec() !== exp_vec() || word_done || frame_done) begin
      bad++; $display("FAIL abort_final got=%h want=%h", obs_vec(), exp_vec());
    end
    step(0, 0, 1);
    total++;
    if (obs_vec() !== exp_vec()) begin
      bad++; $display("FAIL abort_after got=%h want=%h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_cfg_stability();
    int nfd, nerr;
    nfd = 0; nerr = 0;
    cfg_bits = 8; cfg_words = 2;
    step(1, 0, 0);
    cfg_bits = 16; cfg_words = 9;
    for (int i = 0; i < 16; i++) begin
      step(1, 0, 1);
      nfd += int'(frame_done); nerr += int'(cfg_err);
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL stable_tick i=%0d got=%h want=%h", i, obs_vec(), exp_vec());
      end
    end
    total++;
    if (nfd !== 1 || nerr !== 0) begin
      bad++; $display("FAIL stable_count got=%0d/%0d want=1/0", nfd, nerr);
    end
    step(0, 0, 0);
  endtask

  task automatic test_random();
    logic s, a, t;
    for (int i = 0; i < 3000; i++) begin
      cfg_bits  = BIT_W'($urandom_range(0, 9));
      cfg_words = WORD_W'($urandom_range(0, 4));
      s = ($urandom_range(0, 7) == 0);
      a = ($urandom_range(0, 59) == 0);
      t = ($urandom_range(0, 2) != 0);
      step(s, a, t);
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL random i=%0d got=%h want=%h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_reset_mid();
    test_boundary();
    test_invalid();
    test_abort_final();
    test_cfg_stability();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
